// File: rtl/alarm_mode_ctrl.sv
// Alarm clock front-panel controller: time/alarm edit modes, time-counter load,
// alarm compare and the ring/snooze/auto-stop sequence.
module alarm_mode_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm_en,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       time_load,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_en,
  output logic       ringing,
  output logic [2:0] mode,
  output logic       blink
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_TH = 3'd1,
    SET_TM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       edit_hh;
  logic [7:0]       edit_mm;
  logic             match;
  logic             match_q;
  logic             trigger;
  logic             alarm_en_clr;
  logic             leave_run;
  logic             snoozing;
  logic [CNT_W-1:0] ring_cnt;
  logic [CNT_W-1:0] snooze_cnt;

  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)            r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)            r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign mode         = state;
  assign match        = alarm_en && (state == RUN) &&
                        ({hourdec_now, hourone_now} == alarm_hh) &&
                        ({mindec_now, minone_now} == alarm_mm);
  // Edge detect gives exactly one trigger per matching minute.
  assign trigger      = match && !match_q;
  assign alarm_en_clr = btn_alarm_en && alarm_en;
  assign leave_run    = (state == RUN) && btn_mode && !ringing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      edit_hh      <= 8'h00;
      edit_mm      <= 8'h00;
      hourdec_init <= 4'd0;
      hourone_init <= 4'd0;
      mindec_init  <= 4'd0;
      minone_init  <= 4'd0;
      time_load    <= 1'b0;
      alarm_hh     <= 8'h00;
      alarm_mm     <= 8'h00;
      alarm_en     <= 1'b0;
      ringing      <= 1'b0;
      blink        <= 1'b0;
      match_q      <= 1'b0;
      snoozing     <= 1'b0;
      ring_cnt     <= '0;
      snooze_cnt   <= '0;
    end else begin
      time_load <= 1'b0;
      match_q   <= match;

      if (btn_alarm_en) alarm_en <= ~alarm_en;

      // Blink toggles while editing; a mode change below overrides it to 0.
      if (state != RUN && sec_tick) blink <= ~blink;

      case (state)
        RUN: begin
          if (leave_run) begin
            state   <= SET_TH;
            edit_hh <= {hourdec_now, hourone_now};
            edit_mm <= {mindec_now, minone_now};
            blink   <= 1'b0;
          end
        end
        SET_TH: begin
          if (btn_mode) begin
            state <= SET_TM;
            blink <= 1'b0;
          end else if (btn_inc) begin
            edit_hh <= bcd_inc_hour(edit_hh);
          end
        end
        SET_TM: begin
          if (btn_mode) begin
            state        <= SET_AH;
            blink        <= 1'b0;
            hourdec_init <= edit_hh[7:4];
            hourone_init <= edit_hh[3:0];
            mindec_init  <= edit_mm[7:4];
            minone_init  <= edit_mm[3:0];
            time_load    <= 1'b1;
          end else if (btn_inc) begin
            edit_mm <= bcd_inc_min(edit_mm);
          end
        end
        SET_AH: begin
          if (btn_mode) begin
            state <= SET_AM;
            blink <= 1'b0;
          end else if (btn_inc) begin
            alarm_hh <= bcd_inc_hour(alarm_hh);
          end
        end
        SET_AM: begin
          if (btn_mode) begin
            state <= RUN;
            blink <= 1'b0;
          end else if (btn_inc) begin
            alarm_mm <= bcd_inc_min(alarm_mm);
          end
        end
        default: begin
          state <= RUN;
          blink <= 1'b0;
        end
      endcase

      // Ringing only exists in RUN: entering SET_TH is blocked while ringing
      // and cancels any pending snooze, and the match requires RUN.
      if (alarm_en_clr) begin
        ringing    <= 1'b0;
        ring_cnt   <= '0;
        snoozing   <= 1'b0;
        snooze_cnt <= '0;
      end else if (trigger) begin
        ringing    <= 1'b1;
        ring_cnt   <= CNT_W'(RING_SEC);
        snoozing   <= 1'b0;
        snooze_cnt <= '0;
      end else if (leave_run) begin
        snoozing   <= 1'b0;
        snooze_cnt <= '0;
      end else if (ringing) begin
        if (btn_mode) begin
          ringing    <= 1'b0;
          ring_cnt   <= '0;
          snoozing   <= 1'b0;
          snooze_cnt <= '0;
        end else if (btn_inc) begin
          ringing    <= 1'b0;
          ring_cnt   <= '0;
          snoozing   <= 1'b1;
          snooze_cnt <= CNT_W'(SNOOZE_SEC);
        end else if (ring_cnt == '0) begin
          ringing <= 1'b0;
        end else if (sec_tick) begin
          ring_cnt <= ring_cnt - 1'b1;
        end
      end else if (snoozing) begin
        if (snooze_cnt == '0) begin
          snoozing <= 1'b0;
          ringing  <= 1'b1;
          ring_cnt <= CNT_W'(RING_SEC);
        end else if (sec_tick) begin
          snooze_cnt <= snooze_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: time-load scoreboard plus directed mode/ring checks.
module tb_alarm_mode_ctrl;

  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_alarm_en = 1'b0;
  logic [3:0] hourdec_now = 4'd0;
  logic [3:0] hourone_now = 4'd0;
  logic [3:0] mindec_now = 4'd0;
  logic [3:0] minone_now = 4'd0;
  logic [3:0] hourdec_init;
  logic [3:0] hourone_init;
  logic [3:0] mindec_init;
  logic [3:0] minone_init;
  logic       time_load;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_en;
  logic       ringing;
  logic [2:0] mode;
  logic       blink;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [15:0] load_q[$];
  logic [15:0] exp_load;

  alarm_mode_ctrl #(
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sec_tick    (sec_tick),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_alarm_en(btn_alarm_en),
    .hourdec_now (hourdec_now),
    .hourone_now (hourone_now),
    .mindec_now  (mindec_now),
    .minone_now  (minone_now),
    .hourdec_init(hourdec_init),
    .hourone_init(hourone_init),
    .mindec_init (mindec_init),
    .minone_init (minone_init),
    .time_load   (time_load),
    .alarm_hh    (alarm_hh),
    .alarm_mm    (alarm_mm),
    .alarm_en    (alarm_en),
    .ringing     (ringing),
    .mode        (mode),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic m, input logic i, input logic a, input logic s);
    btn_mode = m; btn_inc = i; btn_alarm_en = a; sec_tick = s;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm_en = 1'b0; sec_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_now(input logic [15:0] t);
    {hourdec_now, hourone_now, mindec_now, minone_now} = t;
  endtask

  task automatic retrigger();
    set_now(16'h0731);
    idle(1);
    set_now(16'h0730);
    idle(1);
  endtask

  // Scoreboard: every time_load pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && time_load) begin
      if (load_q.size() == 0) begin
        check("load_unexpected", 1, 0);
      end else begin
        exp_load = load_q.pop_front();
        check("load_init", {hourdec_init, hourone_init, mindec_init, minone_init}, exp_load);
      end
    end
  end

  initial begin
    idle(3);
    check("rst_mode", mode, 0);
    check("rst_ringing", ringing, 0);
    check("rst_alarm_en", alarm_en, 0);
    check("rst_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 0);
    check("rst_load", time_load, 0);
    check("rst_alarm", {alarm_hh, alarm_mm}, 0);
    check("rst_blink", blink, 0);
    rst = 1'b0;
    idle(2);

    // Wraps and mode+inc precedence
    set_now(16'h2359);
    step(1, 0, 0, 0);
    check("wrap_mode_th", mode, 1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("wrap_mode_tm", mode, 2);
    step(0, 1, 0, 0);
    load_q.push_back(16'h0000);
    step(1, 1, 0, 0);
    check("wrap_mode_ah", mode, 3);
    check("wrap_load_pulse", time_load, 1);
    idle(1);
    check("wrap_load_end", time_load, 0);
    step(1, 1, 0, 0);
    check("both_mode_am", mode, 4);
    check("both_inc_dropped", alarm_hh, 8'h00);
    step(1, 0, 0, 0);
    check("back_to_run", mode, 0);

    // 09:58 -> 12:00 load
    set_now(16'h0958);
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    load_q.push_back(16'h1200);
    step(1, 0, 0, 0);
    check("load_mode_ah", mode, 3);
    check("load_pulse", time_load, 1);
    idle(1);
    check("load_pulse_end", time_load, 0);
    check("init_hold", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h1200);

    // Blink in SET_AH, then set alarm 07:30
    check("blink_start", blink, 0);
    step(0, 0, 0, 1);
    check("blink_tog1", blink, 1);
    step(0, 0, 0, 1);
    check("blink_tog2", blink, 0);
    step(0, 0, 0, 1);
    repeat (7) step(0, 1, 0, 0);
    check("alarm_hh_07", alarm_hh, 8'h07);
    step(1, 0, 0, 0);
    check("blink_mode_clr", blink, 0);
    check("mode_am", mode, 4);
    repeat (30) step(0, 1, 0, 0);
    check("alarm_mm_30", alarm_mm, 8'h30);
    step(1, 0, 0, 0);
    check("mode_run", mode, 0);
    step(0, 0, 0, 1);
    check("blink_run", blink, 0);

    // Ring and auto-stop
    step(0, 0, 1, 0);
    check("alarm_en_on", alarm_en, 1);
    set_now(16'h0729);
    idle(2);
    check("no_ring_0729", ringing, 0);
    set_now(16'h0730);
    idle(1);
    check("ring_start", ringing, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("ring_mid", ringing, 1);
    step(0, 0, 0, 1);
    check("ring_last", ringing, 1);
    idle(1);
    check("ring_timeout", ringing, 0);
    idle(10);
    check("no_retrigger", ringing, 0);

    // Snooze, re-ring, dismiss
    retrigger();
    check("ring2_start", ringing, 1);
    step(0, 1, 0, 0);
    check("snooze_stop", ringing, 0);
    repeat (3) step(0, 0, 0, 1);
    check("snooze_wait", ringing, 0);
    step(0, 0, 0, 1);
    idle(1);
    check("snooze_rering", ringing, 1);
    step(1, 0, 0, 0);
    check("dismiss_ring", ringing, 0);
    check("dismiss_mode", mode, 0);
    idle(5);
    check("dismiss_stays", ringing, 0);

    // Snooze cancelled by alarm disable
    retrigger();
    check("ring3_start", ringing, 1);
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    check("en_cleared", alarm_en, 0);
    repeat (6) step(0, 0, 0, 1);
    idle(3);
    check("no_rering", ringing, 0);

    // Reset mid-ring
    step(0, 0, 1, 0);
    retrigger();
    check("ring4_start", ringing, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ringing", ringing, 0);
    check("arst_mode", mode, 0);
    check("arst_alarm_en", alarm_en, 0);
    check("arst_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 0);
    check("arst_alarm", {alarm_hh, alarm_mm}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("post_rst_ringing", ringing, 0);

    check("load_q_drained", load_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
